data_mem_ctrl: RTL and testbench

- Load/store unit between the core datapath's memory port (rd, wr, addr, wr_data, funct3) and a word-organised, synchronous single-port data SRAM.
- Handles byte/halfword/word sizing, byte-enable generation, load sign/zero extension and misalignment detection.
- Stalls the core for a fixed, deterministic access sequence.

---
 rtl/riscv_mem_pkg.sv | 39 +++
 rtl/load_align.sv | 32 +++
 rtl/data_mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
`timescale 1ns/1ps
// Shared load/store definitions: FSM states, RISC-V funct3 size codes and
// request legality helpers used by the data memory controller.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only make sense for loads.
    function automatic logic legal_size(input logic [2:0] funct3, input logic is_store);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic ok;
        case (funct3[1:0])
            2'b01:   ok = !addr_lo[0];
            2'b10:   ok = (addr_lo == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
`timescale 1ns/1ps
// Combinational load formatter: picks the addressed byte/halfword lane from an
// SRAM word and sign- or zero-extends it according to funct3.
module load_align
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_addr_lo,
    input  logic [2:0]        i_funct3,
    output logic [DATA_W-1:0] o_ld_data_next
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_ld_data_next = i_rdata;
        case (i_funct3)
            F3_B:    o_ld_data_next = {{(DATA_W-8){w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data_next = {{(DATA_W-8){1'b0}}, w_byte};
            F3_H:    o_ld_data_next = {{(DATA_W-16){w_half[15]}}, w_half};
            F3_HU:   o_ld_data_next = {{(DATA_W-16){1'b0}}, w_half};
            default: o_ld_data_next = i_rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
`timescale 1ns/1ps
// Load/store unit between the core memory port and a synchronous word SRAM.
// Each legal request runs IDLE -> ACCESS -> RESP, stalling the core for two cycles.
module data_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int WORD_AW = ADDR_W - 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_rd,
    input  logic               req_wr,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [2:0]         req_funct3,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               stall,
    output logic [DATA_W-1:0]  ld_data,
    output logic               ld_valid,
    output logic               err,
    output logic               mem_en,
    output logic               mem_we,
    output logic [3:0]         mem_be,
    output logic [WORD_AW-1:0] mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    mem_state_t          r_state;
    logic                r_is_store;
    logic [1:0]          r_addr_lo;
    logic [2:0]          r_funct3;
    logic                r_ld_valid;
    logic [DATA_W-1:0]   r_ld_hold;
    logic                r_err;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [3:0]          r_mem_be;
    logic [WORD_AW-1:0]  r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_req;
    logic                w_legal;
    logic [3:0]          w_be_st;
    logic [DATA_W-1:0]   w_wdata_st;
    logic [DATA_W-1:0]   w_ld_next;

    assign w_req   = req_rd | req_wr;
    assign w_legal = (req_rd ^ req_wr)
                   & legal_size(req_funct3, req_wr)
                   & is_aligned(req_funct3, req_addr[1:0]);

    always_comb begin
        w_be_st    = 4'b1111;
        w_wdata_st = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be_st    = 4'b0001 << req_addr[1:0];
                w_wdata_st = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be_st    = 4'b0011 << req_addr[1:0];
                w_wdata_st = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be_st    = 4'b1111;
                w_wdata_st = req_wdata;
            end
        endcase
    end

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .i_rdata        (mem_rdata),
        .i_addr_lo      (r_addr_lo),
        .i_funct3       (r_funct3),
        .o_ld_data_next (w_ld_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_is_store  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_funct3    <= 3'b000;
            r_ld_valid  <= 1'b0;
            r_ld_hold   <= '0;
            r_err       <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req && w_legal) begin
                        r_is_store  <= req_wr;
                        r_addr_lo   <= req_addr[1:0];
                        r_funct3    <= req_funct3;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= req_wr;
                        r_mem_addr  <= req_addr[ADDR_W-1:2];
                        r_mem_be    <= req_wr ? w_be_st : 4'b1111;
                        r_mem_wdata <= req_wr ? w_wdata_st : '0;
                        r_state     <= ACCESS;
                    end else if (w_req) begin
                        r_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    r_mem_en   <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_ld_valid <= !r_is_store;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (r_ld_valid)
                        r_ld_hold <= w_ld_next;
                    r_ld_valid <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // SRAM read data only arrives in RESP, so the formatted lane is shown
    // directly then; the last result is held for the idle cycles after.
    assign ld_data   = r_ld_valid ? w_ld_next : r_ld_hold;
    assign ld_valid  = r_ld_valid;
    assign err       = r_err;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign stall     = ((r_state == IDLE) & w_req & w_legal) | (r_state == ACCESS);

endmodule

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
// Directed bench for data_mem_ctrl with a behavioural byte-enabled SRAM.
module tb_data_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        req_rd, req_wr;
    logic [8:0]  req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        stall, ld_valid, err, mem_en, mem_we;
    logic [31:0] ld_data, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [6:0]  mem_addr;
    logic [31:0] sram [128];

    int vec  = 0;
    int errs = 0;

    data_mem_ctrl dut (
        .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [8:0] a,
                         input logic [2:0] f, input logic [31:0] d);
        req_rd = rd; req_wr = wr; req_addr = a; req_funct3 = f; req_wdata = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 9'h000, 3'b000, 32'h0);
        smp();
        vec++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errs++; $display("FAIL rst_en_we got %b%b exp 00", mem_en, mem_we); end
        vec++; if (mem_be !== 4'h0 || mem_addr !== 7'h0) begin errs++; $display("FAIL rst_be_addr got %h %h exp 0 0", mem_be, mem_addr); end
        vec++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL rst_wdata got %h exp 0", mem_wdata); end
        vec++; if (ld_data !== 32'h0 || ld_valid !== 1'b0) begin errs++; $display("FAIL rst_ld got %h %b exp 0 0", ld_data, ld_valid); end
        vec++; if (err !== 1'b0 || stall !== 1'b0) begin errs++; $display("FAIL rst_err_stall got %b %b exp 0 0", err, stall); end
        smp();
        reset = 1'b1;
    endtask

    task automatic test_sw_lw();
        nxt(); drive(0, 1, 9'h010, 3'b010, 32'hDEADBEEF);
        smp();
        vec++; if (stall !== 1'b1 || mem_en !== 1'b0) begin errs++; $display("FAIL sw_req got stall %b en %b exp 1 0", stall, mem_en); end
        nxt(); smp();
        vec++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errs++; $display("FAIL sw_acc_en got %b%b exp 11", mem_en, mem_we); end
        vec++; if (mem_be !== 4'b1111 || mem_addr !== 7'h04) begin errs++; $display("FAIL sw_acc_be got %b %h exp 1111 04", mem_be, mem_addr); end
        vec++; if (mem_wdata !== 32'hDEADBEEF || stall !== 1'b1) begin errs++; $display("FAIL sw_acc_wd got %h %b exp deadbeef 1", mem_wdata, stall); end
        nxt(); smp();
        vec++; if (stall !== 1'b0 || mem_en !== 1'b0 || ld_valid !== 1'b0) begin errs++; $display("FAIL sw_resp got %b %b %b exp 000", stall, mem_en, ld_valid); end
        nxt(); drive(1, 0, 9'h010, 3'b010, 32'h0);
        smp();
        vec++; if (stall !== 1'b1) begin errs++; $display("FAIL lw_stall0 got %b exp 1", stall); end
        nxt(); smp();
        vec++; if (stall !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin errs++; $display("FAIL lw_acc got %b %b %b exp 110", stall, mem_en, mem_we); end
        vec++; if (mem_be !== 4'b1111 || mem_addr !== 7'h04) begin errs++; $display("FAIL lw_acc_be got %b %h exp 1111 04", mem_be, mem_addr); end
        nxt(); smp();
        vec++; if (ld_valid !== 1'b1 || ld_data !== 32'hDEADBEEF || stall !== 1'b0) begin errs++; $display("FAIL lw_resp got %b %h %b exp 1 deadbeef 0", ld_valid, ld_data, stall); end
        nxt(); drive(0, 0, 9'h000, 3'b000, 32'h0);
        smp();
        vec++; if (ld_valid !== 1'b0 || ld_data !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_hold got %b %h exp 0 deadbeef", ld_valid, ld_data); end
    endtask

    task automatic test_byte();
        nxt(); drive(0, 1, 9'h013, 3'b000, 32'h00000080);
        nxt(); smp();
        vec++; if (mem_be !== 4'b1000 || mem_wdata !== 32'h80808080) begin errs++; $display("FAIL sb_acc got %b %h exp 1000 80808080", mem_be, mem_wdata); end
        vec++; if (mem_addr !== 7'h04) begin errs++; $display("FAIL sb_addr got %h exp 04", mem_addr); end
        nxt(); nxt(); drive(1, 0, 9'h013, 3'b000, 32'h0);
        nxt(); nxt(); smp();
        vec++; if (ld_valid !== 1'b1 || ld_data !== 32'hFFFFFF80) begin errs++; $display("FAIL lb got %b %h exp 1 ffffff80", ld_valid, ld_data); end
        nxt(); drive(1, 0, 9'h013, 3'b100, 32'h0);
        nxt(); nxt(); smp();
        vec++; if (ld_valid !== 1'b1 || ld_data !== 32'h00000080) begin errs++; $display("FAIL lbu got %b %h exp 1 00000080", ld_valid, ld_data); end
    endtask

    task automatic test_half();
        nxt(); drive(0, 1, 9'h022, 3'b001, 32'h00008001);
        nxt(); smp();
        vec++; if (mem_be !== 4'b1100 || mem_wdata !== 32'h80018001 || mem_addr !== 7'h08) begin errs++; $display("FAIL sh_acc got %b %h %h exp 1100 80018001 08", mem_be, mem_wdata, mem_addr); end
        nxt(); nxt(); drive(1, 0, 9'h022, 3'b001, 32'h0);
        nxt(); nxt(); smp();
        vec++; if (ld_valid !== 1'b1 || ld_data !== 32'hFFFF8001) begin errs++; $display("FAIL lh got %b %h exp 1 ffff8001", ld_valid, ld_data); end
        nxt(); drive(1, 0, 9'h022, 3'b101, 32'h0);
        nxt(); nxt(); smp();
        vec++; if (ld_valid !== 1'b1 || ld_data !== 32'h00008001) begin errs++; $display("FAIL lhu got %b %h exp 1 00008001", ld_valid, ld_data); end
    endtask

    task automatic test_errors();
        logic       rd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       wr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [8:0] ad [5] = '{9'h011, 9'h003, 9'h010, 9'h010, 9'h010};
        logic [2:0] f3 [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
        for (int i = 0; i < 5; i++) begin
            nxt(); drive(rd[i], wr[i], ad[i], f3[i], 32'h12345678);
            smp();
            vec++; if (stall !== 1'b0 || mem_en !== 1'b0) begin errs++; $display("FAIL err%0d_req got stall %b en %b exp 0 0", i, stall, mem_en); end
            nxt(); drive(0, 0, 9'h000, 3'b000, 32'h0);
            smp();
            vec++; if (err !== 1'b1 || mem_en !== 1'b0) begin errs++; $display("FAIL err%0d_pulse got err %b en %b exp 1 0", i, err, mem_en); end
            vec++; if (ld_valid !== 1'b0 || ld_data !== 32'h00008001) begin errs++; $display("FAIL err%0d_ld got %b %h exp 0 00008001", i, ld_valid, ld_data); end
            nxt(); smp();
            vec++; if (err !== 1'b0 || mem_en !== 1'b0) begin errs++; $display("FAIL err%0d_end got err %b en %b exp 0 0", i, err, mem_en); end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_v = 7'b0100100;
        logic [6:0] exp_s = 7'b0011011;
        for (int c = 0; c < 7; c++) begin
            nxt();
            if (c < 3)      drive(1, 0, 9'h000, 3'b010, 32'h0);
            else if (c < 6) drive(1, 0, 9'h004, 3'b010, 32'h0);
            else            drive(0, 0, 9'h000, 3'b000, 32'h0);
            smp();
            vec++; if (ld_valid !== exp_v[c] || stall !== exp_s[c]) begin errs++; $display("FAIL b2b_c%0d got v %b s %b exp %b %b", c, ld_valid, stall, exp_v[c], exp_s[c]); end
            if (c == 2) begin
                vec++; if (ld_data !== 32'h11223344) begin errs++; $display("FAIL b2b_d0 got %h exp 11223344", ld_data); end
            end
            if (c == 4) begin
                vec++; if (mem_en !== 1'b1 || mem_addr !== 7'h01) begin errs++; $display("FAIL b2b_acc1 got %b %h exp 1 01", mem_en, mem_addr); end
            end
            if (c == 5) begin
                vec++; if (ld_data !== 32'h55667788) begin errs++; $display("FAIL b2b_d1 got %h exp 55667788", ld_data); end
            end
        end
    endtask

    task automatic test_reset_mid();
        nxt(); drive(1, 0, 9'h010, 3'b010, 32'h0);
        nxt(); smp();
        vec++; if (mem_en !== 1'b1) begin errs++; $display("FAIL rm_acc got %b exp 1", mem_en); end
        #2; reset = 1'b0; drive(0, 0, 9'h000, 3'b000, 32'h0);
        #1;
        vec++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 7'h0) begin errs++; $display("FAIL rm_mem got %b %b %b %h exp 0 0 0 0", mem_en, mem_we, mem_be, mem_addr); end
        vec++; if (ld_valid !== 1'b0 || ld_data !== 32'h0 || err !== 1'b0 || stall !== 1'b0) begin errs++; $display("FAIL rm_out got %b %h %b %b exp 0 0 0 0", ld_valid, ld_data, err, stall); end
        smp();
        reset = 1'b1;
        nxt(); drive(1, 0, 9'h010, 3'b010, 32'h0);
        smp();
        vec++; if (stall !== 1'b1) begin errs++; $display("FAIL rm_idle_accept got %b exp 1", stall); end
        nxt(); nxt(); smp();
        vec++; if (ld_valid !== 1'b1 || ld_data !== 32'h80ADBEEF) begin errs++; $display("FAIL rm_lw got %b %h exp 1 80adbeef", ld_valid, ld_data); end
        nxt(); drive(0, 0, 9'h000, 3'b000, 32'h0);
        smp();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) sram[i] = 32'h0;
        sram[0] = 32'h11223344;
        sram[1] = 32'h55667788;
        mem_rdata = 32'h0;
        test_reset();
        test_sw_lw();
        test_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
